// File: rtl/fb_bank_scheduler.sv
// Framebuffer bank scheduler between the LCD capture writer and the imageGen reader.
// Hands out banks for double/triple buffering so the scanned frame never tears.
module fb_bank_scheduler #(
  parameter int unsigned NUM_BANKS = 3,
  parameter int unsigned BANK_W    = 2,
  parameter int unsigned ADDR_W    = 14
) (
  input  logic                     pxlClk,
  input  logic                     rst,
  input  logic                     wrFrameStart,
  input  logic                     wrFrameDone,
  input  logic [ADDR_W-1:0]        wrAddrIn,
  output logic                     wrEnOk,
  output logic [BANK_W-1:0]        wrBank,
  output logic [BANK_W+ADDR_W-1:0] wrAddrOut,
  input  logic                     rdFrameStart,
  input  logic [ADDR_W-1:0]        rdAddrIn,
  output logic [BANK_W-1:0]        rdBank,
  output logic [BANK_W+ADDR_W-1:0] rdAddrOut,
  output logic                     rdValid,
  output logic [7:0]               dropCnt,
  output logic [7:0]               repeatCnt,
  output logic [7:0]               abortCnt
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    TAG_FREE,
    TAG_WRITING,
    TAG_READY,
    TAG_DISPLAY
  } tag_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ACTIVE,
    W_BLOCKED
  } wr_state_t;

  tag_t              tag     [NUM_BANKS];
  tag_t              tag_nxt [NUM_BANKS];
  wr_state_t         wr_state;
  wr_state_t         wr_state_nxt;
  logic [BANK_W-1:0] wr_bank_nxt;
  logic [BANK_W-1:0] rd_bank_nxt;
  logic              wr_en_nxt;
  logic              rd_valid_nxt;
  logic              drop_inc;
  logic              repeat_inc;
  logic              abort_inc;
  logic              ready_found;
  logic [BANK_W-1:0] ready_idx;
  logic              free_found;
  logic [BANK_W-1:0] free_idx;

  // Same-cycle events are applied in order: writer done, read swap, writer start.
  always_comb begin
    tag_nxt      = tag;
    wr_state_nxt = wr_state;
    wr_bank_nxt  = wrBank;
    wr_en_nxt    = wrEnOk;
    rd_bank_nxt  = rdBank;
    rd_valid_nxt = rdValid;
    drop_inc     = 1'b0;
    repeat_inc   = 1'b0;
    abort_inc    = 1'b0;
    ready_found  = 1'b0;
    ready_idx    = '0;
    free_found   = 1'b0;
    free_idx     = '0;

    if (wrFrameDone) begin
      if (wr_state == W_ACTIVE) begin
        // A frame still waiting to be shown is overtaken by the newer one.
        for (int i = 0; i < int'(NUM_BANKS); i++) begin
          if (tag_nxt[i] == TAG_READY) begin
            tag_nxt[i] = TAG_FREE;
            drop_inc   = 1'b1;
          end else if (tag_nxt[i] == TAG_WRITING) begin
            tag_nxt[i] = TAG_READY;
          end
        end
        wr_state_nxt = W_IDLE;
        wr_en_nxt    = 1'b0;
      end else if (wr_state == W_BLOCKED) begin
        drop_inc     = 1'b1;
        wr_state_nxt = W_IDLE;
      end
    end

    if (rdFrameStart) begin
      for (int i = 0; i < int'(NUM_BANKS); i++) begin
        if (tag_nxt[i] == TAG_READY) begin
          ready_found = 1'b1;
          ready_idx   = BANK_W'(i);
        end
      end
      if (ready_found) begin
        for (int i = 0; i < int'(NUM_BANKS); i++) begin
          if (tag_nxt[i] == TAG_DISPLAY) begin
            tag_nxt[i] = TAG_FREE;
          end else if (tag_nxt[i] == TAG_READY) begin
            tag_nxt[i] = TAG_DISPLAY;
          end
        end
        rd_bank_nxt  = ready_idx;
        rd_valid_nxt = 1'b1;
      end else begin
        repeat_inc = 1'b1;
      end
    end

    if (wrFrameStart) begin
      if (wr_state_nxt == W_ACTIVE) begin
        // Restart on the same bank; the partial frame is simply overwritten.
        abort_inc = 1'b1;
      end else begin
        for (int i = 0; i < int'(NUM_BANKS); i++) begin
          if (!free_found && tag_nxt[i] == TAG_FREE) begin
            free_found = 1'b1;
            free_idx   = BANK_W'(i);
          end
        end
        if (free_found) begin
          for (int i = 0; i < int'(NUM_BANKS); i++) begin
            if (BANK_W'(i) == free_idx) begin
              tag_nxt[i] = TAG_WRITING;
            end
          end
          wr_state_nxt = W_ACTIVE;
          wr_bank_nxt  = free_idx;
          wr_en_nxt    = 1'b1;
        end else begin
          wr_state_nxt = W_BLOCKED;
          wr_en_nxt    = 1'b0;
        end
      end
    end
  end

  // State, bank tags, registered outputs and saturating debug counters.
  always_ff @(posedge pxlClk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_BANKS); i++) begin
        tag[i] <= (i == 0) ? TAG_DISPLAY : TAG_FREE;
      end
      wr_state  <= W_IDLE;
      wrBank    <= BANK_W'(1);
      wrEnOk    <= 1'b0;
      rdBank    <= '0;
      rdValid   <= 1'b0;
      dropCnt   <= '0;
      repeatCnt <= '0;
      abortCnt  <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_BANKS); i++) begin
        tag[i] <= tag_nxt[i];
      end
      wr_state <= wr_state_nxt;
      wrBank   <= wr_bank_nxt;
      wrEnOk   <= wr_en_nxt;
      rdBank   <= rd_bank_nxt;
      rdValid  <= rd_valid_nxt;
      if (drop_inc && dropCnt != {CNT_W{1'b1}}) begin
        dropCnt <= dropCnt + CNT_W'(1);
      end
      if (repeat_inc && repeatCnt != {CNT_W{1'b1}}) begin
        repeatCnt <= repeatCnt + CNT_W'(1);
      end
      if (abort_inc && abortCnt != {CNT_W{1'b1}}) begin
        abortCnt <= abortCnt + CNT_W'(1);
      end
    end
  end

  assign wrAddrOut = {wrBank, wrAddrIn};
  assign rdAddrOut = {rdBank, rdAddrIn};

endmodule

// File: tb/tb_fb_bank_scheduler.sv
// Bench for fb_bank_scheduler: triple- and double-buffered instances share stimulus
// and are compared against a set-based bank model, hand tables and corner sequences.
module tb_fb_bank_scheduler;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned BANK_W = 2;

  logic pxlClk = 1'b0;
  always #5 pxlClk = ~pxlClk;

  logic                     rst;
  logic                     wrFrameStart;
  logic                     wrFrameDone;
  logic                     rdFrameStart;
  logic [ADDR_W-1:0]        wrAddrIn;
  logic [ADDR_W-1:0]        rdAddrIn;

  logic                     a_wrEnOk, b_wrEnOk;
  logic [BANK_W-1:0]        a_wrBank, b_wrBank;
  logic [BANK_W-1:0]        a_rdBank, b_rdBank;
  logic [BANK_W+ADDR_W-1:0] a_wrAddrOut, b_wrAddrOut;
  logic [BANK_W+ADDR_W-1:0] a_rdAddrOut, b_rdAddrOut;
  logic                     a_rdValid, b_rdValid;
  logic [7:0]               a_dropCnt, b_dropCnt;
  logic [7:0]               a_repeatCnt, b_repeatCnt;
  logic [7:0]               a_abortCnt, b_abortCnt;

  fb_bank_scheduler #(.NUM_BANKS(3), .BANK_W(BANK_W), .ADDR_W(ADDR_W)) dut3 (
    .pxlClk(pxlClk), .rst(rst),
    .wrFrameStart(wrFrameStart), .wrFrameDone(wrFrameDone), .wrAddrIn(wrAddrIn),
    .wrEnOk(a_wrEnOk), .wrBank(a_wrBank), .wrAddrOut(a_wrAddrOut),
    .rdFrameStart(rdFrameStart), .rdAddrIn(rdAddrIn),
    .rdBank(a_rdBank), .rdAddrOut(a_rdAddrOut), .rdValid(a_rdValid),
    .dropCnt(a_dropCnt), .repeatCnt(a_repeatCnt), .abortCnt(a_abortCnt)
  );

  fb_bank_scheduler #(.NUM_BANKS(2), .BANK_W(BANK_W), .ADDR_W(ADDR_W)) dut2 (
    .pxlClk(pxlClk), .rst(rst),
    .wrFrameStart(wrFrameStart), .wrFrameDone(wrFrameDone), .wrAddrIn(wrAddrIn),
    .wrEnOk(b_wrEnOk), .wrBank(b_wrBank), .wrAddrOut(b_wrAddrOut),
    .rdFrameStart(rdFrameStart), .rdAddrIn(rdAddrIn),
    .rdBank(b_rdBank), .rdAddrOut(b_rdAddrOut), .rdValid(b_rdValid),
    .dropCnt(b_dropCnt), .repeatCnt(b_repeatCnt), .abortCnt(b_abortCnt)
  );

  // Model: which bank is shown, pending, being written; free = everything else.
  typedef struct {
    int disp;
    int ready;
    int writing;
    bit blocked;
    int wrbank;
    bit rdvalid;
    int drop;
    int rep;
    int abrt;
  } model_t;

  typedef struct {
    bit r;
    bit d;
    bit rd;
    bit s;
    int wb;
    int we;
    int rb;
    int rv;
    int drop;
    int rep;
    int abrt;
  } vec_t;

  int checks = 0;
  int failures = 0;
  model_t m3, m2;
  vec_t vt[$];

  function automatic int sat(input int x);
    return (x > 255) ? 255 : x;
  endfunction

  function automatic model_t m_reset();
    model_t m;
    m.disp = 0; m.ready = -1; m.writing = -1; m.blocked = 1'b0;
    m.wrbank = 1; m.rdvalid = 1'b0; m.drop = 0; m.rep = 0; m.abrt = 0;
    return m;
  endfunction

  function automatic model_t m_step(input model_t m, input int nb,
                                    input bit done, input bit rd, input bit start);
    int f;
    if (done) begin
      if (m.writing >= 0) begin
        if (m.ready >= 0) m.drop = sat(m.drop + 1);
        m.ready = m.writing;
        m.writing = -1;
      end else if (m.blocked) begin
        m.drop = sat(m.drop + 1);
        m.blocked = 1'b0;
      end
    end
    if (rd) begin
      if (m.ready >= 0) begin
        m.disp = m.ready;
        m.ready = -1;
        m.rdvalid = 1'b1;
      end else begin
        m.rep = sat(m.rep + 1);
      end
    end
    if (start) begin
      if (m.writing >= 0) begin
        m.abrt = sat(m.abrt + 1);
      end else begin
        f = -1;
        for (int b = 0; b < nb; b++)
          if (f < 0 && b != m.disp && b != m.ready) f = b;
        if (f >= 0) begin
          m.writing = f;
          m.wrbank = f;
          m.blocked = 1'b0;
        end else begin
          m.blocked = 1'b1;
        end
      end
    end
    return m;
  endfunction

  function automatic vec_t v(input bit r, input bit d, input bit rd, input bit s,
                             input int wb, input int we, input int rb, input int rv,
                             input int drop, input int rep, input int abrt);
    vec_t x;
    x.r = r; x.d = d; x.rd = rd; x.s = s;
    x.wb = wb; x.we = we; x.rb = rb; x.rv = rv;
    x.drop = drop; x.rep = rep; x.abrt = abrt;
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_models();
    chk("n3.wrEnOk",    int'(a_wrEnOk),    int'(m3.writing >= 0));
    chk("n3.wrBank",    int'(a_wrBank),    m3.wrbank);
    chk("n3.rdBank",    int'(a_rdBank),    m3.disp);
    chk("n3.rdValid",   int'(a_rdValid),   int'(m3.rdvalid));
    chk("n3.dropCnt",   int'(a_dropCnt),   m3.drop);
    chk("n3.repeatCnt", int'(a_repeatCnt), m3.rep);
    chk("n3.abortCnt",  int'(a_abortCnt),  m3.abrt);
    chk("n3.wrAddrOut", int'(a_wrAddrOut), (m3.wrbank << ADDR_W) | int'(wrAddrIn));
    chk("n3.rdAddrOut", int'(a_rdAddrOut), (m3.disp << ADDR_W) | int'(rdAddrIn));
    chk("n2.wrEnOk",    int'(b_wrEnOk),    int'(m2.writing >= 0));
    chk("n2.wrBank",    int'(b_wrBank),    m2.wrbank);
    chk("n2.rdBank",    int'(b_rdBank),    m2.disp);
    chk("n2.rdValid",   int'(b_rdValid),   int'(m2.rdvalid));
    chk("n2.dropCnt",   int'(b_dropCnt),   m2.drop);
    chk("n2.repeatCnt", int'(b_repeatCnt), m2.rep);
    chk("n2.abortCnt",  int'(b_abortCnt),  m2.abrt);
    chk("n2.wrAddrOut", int'(b_wrAddrOut), (m2.wrbank << ADDR_W) | int'(wrAddrIn));
    chk("n2.rdAddrOut", int'(b_rdAddrOut), (m2.disp << ADDR_W) | int'(rdAddrIn));
  endtask

  // One clock with the given pulses, then step the models and compare.
  task automatic apply(input bit r, input bit d, input bit rd, input bit s);
    @(negedge pxlClk);
    rst = r; wrFrameDone = d; rdFrameStart = rd; wrFrameStart = s;
    wrAddrIn = ADDR_W'($urandom);
    rdAddrIn = ADDR_W'($urandom);
    @(posedge pxlClk);
    #1;
    rst = 1'b0; wrFrameDone = 1'b0; rdFrameStart = 1'b0; wrFrameStart = 1'b0;
    if (r) begin
      m3 = m_reset();
      m2 = m_reset();
    end else begin
      m3 = m_step(m3, 3, d, rd, s);
      m2 = m_step(m2, 2, d, rd, s);
    end
    check_models();
  endtask

  initial begin
    rst = 1'b0; wrFrameStart = 1'b0; wrFrameDone = 1'b0; rdFrameStart = 1'b0;
    wrAddrIn = '0; rdAddrIn = '0;
    m3 = m_reset();
    m2 = m_reset();

    //            r d rd s   wb we rb rv drop rep ab   (triple-buffered instance)
    vt.push_back(v(1,0,0,0,  1, 0, 0, 0, 0,  0, 0));
    vt.push_back(v(0,0,0,1,  1, 1, 0, 0, 0,  0, 0));
    vt.push_back(v(0,1,0,0,  1, 0, 0, 0, 0,  0, 0));
    vt.push_back(v(0,0,1,0,  1, 0, 1, 1, 0,  0, 0));
    vt.push_back(v(0,0,0,1,  0, 1, 1, 1, 0,  0, 0));
    vt.push_back(v(1,0,0,0,  1, 0, 0, 0, 0,  0, 0));
    vt.push_back(v(0,0,0,1,  1, 1, 0, 0, 0,  0, 0));
    vt.push_back(v(0,1,0,0,  1, 0, 0, 0, 0,  0, 0));
    vt.push_back(v(0,0,0,1,  2, 1, 0, 0, 0,  0, 0));
    vt.push_back(v(0,1,0,0,  2, 0, 0, 0, 1,  0, 0));
    vt.push_back(v(0,0,1,0,  2, 0, 2, 1, 1,  0, 0));
    vt.push_back(v(0,0,0,1,  0, 1, 2, 1, 1,  0, 0));
    vt.push_back(v(0,1,1,1,  1, 1, 0, 1, 1,  0, 0));
    vt.push_back(v(0,0,0,1,  1, 1, 0, 1, 1,  0, 1));
    vt.push_back(v(0,0,1,0,  1, 1, 0, 1, 1,  1, 1));
    vt.push_back(v(0,1,0,0,  1, 0, 0, 1, 1,  1, 1));
    vt.push_back(v(0,1,0,0,  1, 0, 0, 1, 1,  1, 1));
    vt.push_back(v(1,0,0,0,  1, 0, 0, 0, 0,  0, 0));
    vt.push_back(v(0,0,1,0,  1, 0, 0, 0, 0,  1, 0));
    vt.push_back(v(0,0,1,0,  1, 0, 0, 0, 0,  2, 0));
    vt.push_back(v(0,0,1,0,  1, 0, 0, 0, 0,  3, 0));
    vt.push_back(v(1,0,0,0,  1, 0, 0, 0, 0,  0, 0));
    vt.push_back(v(0,0,0,1,  1, 1, 0, 0, 0,  0, 0));
    vt.push_back(v(0,0,0,1,  1, 1, 0, 0, 0,  0, 1));
    vt.push_back(v(1,0,0,1,  1, 0, 0, 0, 0,  0, 0));
    vt.push_back(v(0,0,0,0,  1, 0, 0, 0, 0,  0, 0));

    foreach (vt[k]) begin
      apply(vt[k].r, vt[k].d, vt[k].rd, vt[k].s);
      chk($sformatf("vec%0d.wrBank", k),    int'(a_wrBank),    vt[k].wb);
      chk($sformatf("vec%0d.wrEnOk", k),    int'(a_wrEnOk),    vt[k].we);
      chk($sformatf("vec%0d.rdBank", k),    int'(a_rdBank),    vt[k].rb);
      chk($sformatf("vec%0d.rdValid", k),   int'(a_rdValid),   vt[k].rv);
      chk($sformatf("vec%0d.dropCnt", k),   int'(a_dropCnt),   vt[k].drop);
      chk($sformatf("vec%0d.repeatCnt", k), int'(a_repeatCnt), vt[k].rep);
      chk($sformatf("vec%0d.abortCnt", k),  int'(a_abortCnt),  vt[k].abrt);
    end

    // Double buffering: second start while a swap is pending blocks the frame.
    apply(1, 0, 0, 0);
    apply(0, 0, 0, 1);
    chk("db.start.wrBank", int'(b_wrBank), 1);
    chk("db.start.wrEnOk", int'(b_wrEnOk), 1);
    apply(0, 1, 0, 0);
    apply(0, 0, 0, 1);
    chk("db.blocked.wrEnOk", int'(b_wrEnOk), 0);
    chk("db.blocked.dropCnt", int'(b_dropCnt), 0);
    apply(0, 1, 0, 0);
    chk("db.blockdone.dropCnt", int'(b_dropCnt), 1);
    apply(0, 0, 1, 0);
    chk("db.swap.rdBank", int'(b_rdBank), 1);
    chk("db.swap.rdValid", int'(b_rdValid), 1);
    apply(0, 0, 0, 1);
    chk("db.next.wrBank", int'(b_wrBank), 0);
    chk("db.next.wrEnOk", int'(b_wrEnOk), 1);
    // Done, read and start together: freed display bank goes straight to the writer.
    apply(0, 1, 1, 1);
    chk("db.same.rdBank", int'(b_rdBank), 0);
    chk("db.same.wrBank", int'(b_wrBank), 1);
    chk("db.same.wrEnOk", int'(b_wrEnOk), 1);
    chk("db.same.repeatCnt", int'(b_repeatCnt), 0);

    // A bank freeing mid-frame does not unblock the skipped frame.
    apply(1, 0, 0, 0);
    apply(0, 0, 0, 1);
    apply(0, 1, 0, 0);
    apply(0, 0, 0, 1);
    apply(0, 0, 1, 0);
    chk("db.midfree.wrEnOk", int'(b_wrEnOk), 0);
    chk("db.midfree.rdBank", int'(b_rdBank), 1);
    apply(0, 1, 0, 0);
    chk("db.midfree.dropCnt", int'(b_dropCnt), 1);
    chk("db.midfree.idle.wrEnOk", int'(b_wrEnOk), 0);
    apply(0, 0, 0, 1);
    chk("db.midfree.restart.wrBank", int'(b_wrBank), 0);
    chk("db.midfree.restart.wrEnOk", int'(b_wrEnOk), 1);

    // Repeat counter saturation.
    apply(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) apply(0, 0, 1, 0);
    chk("rep3.repeatCnt", int'(a_repeatCnt), 3);
    chk("rep3.rdValid", int'(a_rdValid), 0);
    chk("rep3.rdBank", int'(a_rdBank), 0);
    for (int i = 0; i < 300; i++) apply(0, 0, 1, 0);
    chk("repsat.n3", int'(a_repeatCnt), 255);
    chk("repsat.n2", int'(b_repeatCnt), 255);

    // Randomized traffic with occasional resets.
    apply(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      apply($urandom_range(0, 249) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
